mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- MEM-stage data-memory initiator of the lc3b pipeline.
- Consumes the EX-stage effective address, ALU result and store data, then drives the data-memory handshake.
- Covers word/byte loads and stores, plus the two-access indirect forms LDI/STI.
- Stalls the pipeline while an access is in flight and returns load data to WB.

Parameters:
- WIDTH, 16, data/address word width. Only 16 is supported; byte lanes are fixed at 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM-stage instruction valid
- mem_op  in  3  000 none, 001 LDR, 010 LDB, 011 STR, 100 STB, 101 LDI, 110 STI, 111 reserved (treated as none)
- mem_flush  in  1  squash current MEM-stage instruction
- mem_address  in  WIDTH  effective address from EX
- mem_store_data  in  WIDTH  SR value for stores
- dmem_address  out  WIDTH  data-memory address
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_byte_enable  out  2  lane enables, [1] high byte
- dmem_wdata  out  WIDTH  write data
- dmem_rdata  in  WIDTH  read data, valid with dmem_resp
- dmem_resp  in  1  one-cycle access-complete pulse
- mem_rdata  out  WIDTH  load result to WB
- mem_stall  out  1  hold IF..MEM pipeline registers
- mem_done  out  1  one-cycle pulse: memory op retired this cycle

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; pointer and load registers clear.
  - dmem_read, dmem_write, mem_done = 0; dmem_byte_enable = 00; dmem_address, dmem_wdata, mem_rdata = 0.
  - Reset mid-access drops requests immediately; a later dmem_resp is ignored.
- start = mem_valid & ~mem_flush & mem_op in {001..110}.
- FSM states: IDLE, IND, ACC, DONE. All dmem_* outputs are registered, decoded from the next state.
- IDLE:
  - start with LDI/STI -> IND; other start -> ACC; else stay.
  - mem_stall = start (combinational).
  - Non-memory or flushed ops: no stall, no dmem activity, mem_rdata holds its value.
- IND:
  - dmem_read=1, dmem_address = {mem_address[15:1],0}, byte_enable=11.
  - On dmem_resp: ptr <= dmem_rdata. If mem_flush -> IDLE (pointer read has no side effect). Else -> ACC.
  - mem_stall=1.
- ACC:
  - Base address = ptr for LDI/STI, else mem_address.
  - Word ops (LDR/LDI/STR/STI): address bit 0 forced to 0, byte_enable=11, wdata = mem_store_data.
  - Byte ops (LDB/STB): address unmodified, byte_enable = addr[0] ? 10 : 01, wdata = {store_data[7:0], store_data[7:0]}.
  - Loads drive dmem_read=1; stores drive dmem_write=1.
  - mem_flush is ignored once ACC is entered.
  - On dmem_resp: loads latch mem_rdata. Word loads take rdata. Byte loads zero-extend the selected byte: addr[0] ? rdata[15:8] : rdata[7:0]. Then -> DONE.
  - mem_stall=1.
- DONE:
  - Requests deasserted, mem_stall=0, mem_done=1, mem_rdata valid for WB capture.
  - Always -> IDLE; the next instruction is evaluated in IDLE next cycle.
- Latency with zero-wait memory (resp in the first request cycle): LDR/STR take 3 cycles with 2 stalled; LDI/STI take 4 cycles with 3 stalled.
- Stores leave mem_rdata unchanged.
- Inputs must be held stable while mem_stall=1 (pipeline is frozen).
- Requests stay asserted with constant address/data until dmem_resp.
- dmem_resp in IDLE or DONE is ignored.
- Never assert dmem_read and dmem_write together.

Test Plan:
- LDR: addr 0x3005, rdata 0xBEEF, resp after 2 wait cycles -> dmem_address 0x3004, BE 11, mem_rdata 0xBEEF, mem_done one cycle, stall 4 cycles total.
- LDB/STB: LDB at 0x4001 with rdata 0xA55A -> mem_rdata 0x00A5. STB 0x4000 with data 0x12CD -> BE 01, wdata 0xCDCD.
- LDI: addr 0x2000; first resp returns 0x6003, second returns 0x1111 -> second access uses address 0x6002, mem_rdata 0x1111, 3 stall cycles with zero wait.
- STI: pointer 0x7000, data 0x55AA -> write to 0x7000, BE 11, wdata 0x55AA, read and write never overlap.
- Flush: flush in IDLE gives no request and no stall. Flush during IND returns to IDLE after resp with no write. Flush during ACC still completes the access.
- Reset: rst_n low while ACC is asserting dmem_write -> write drops same cycle, all outputs 0, a late resp after reset leaves the FSM in IDLE.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory initiator for the lc3b pipeline: issues word/byte and
// indirect (LDI/STI) accesses, stalls the pipe while in flight, returns load data.
module mem_stage_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  input  logic [2:0]       mem_op,
  input  logic             mem_flush,
  input  logic [WIDTH-1:0] mem_address,
  input  logic [WIDTH-1:0] mem_store_data,
  output logic [WIDTH-1:0] dmem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [1:0]       dmem_byte_enable,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_resp,
  output logic [WIDTH-1:0] mem_rdata,
  output logic             mem_stall,
  output logic             mem_done
);

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_LDR  = 3'b001;
  localparam logic [2:0] OP_LDB  = 3'b010;
  localparam logic [2:0] OP_STR  = 3'b011;
  localparam logic [2:0] OP_STB  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_STI  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_IND, S_ACC, S_DONE} state_e;

  function automatic logic op_is_ind(input logic [2:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic op_is_load(input logic [2:0] op);
    return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI);
  endfunction

  function automatic logic op_is_byte(input logic [2:0] op);
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [1:0]       be_q, be_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             start;
  logic [WIDTH-1:0] base;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    start     = mem_valid && !mem_flush && (mem_op != OP_NONE) && (mem_op != OP_RSVD);
    state_d   = state_q;
    op_d      = op_q;
    rdata_d   = rdata_q;
    mem_stall = 1'b0;
    base      = '0;

    unique case (state_q)
      S_IDLE: begin
        mem_stall = start;
        if (start) begin
          op_d    = mem_op;
          state_d = op_is_ind(mem_op) ? S_IND : S_ACC;
        end
      end
      S_IND: begin
        mem_stall = 1'b1;
        // A squashed pointer read has no side effect, so abandon it on completion.
        if (dmem_resp) state_d = mem_flush ? S_IDLE : S_ACC;
      end
      S_ACC: begin
        mem_stall = 1'b1;
        if (dmem_resp) begin
          state_d = S_DONE;
          if (op_is_load(op_q)) begin
            if (op_is_byte(op_q))
              rdata_d = {8'h00, addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]};
            else
              rdata_d = dmem_rdata;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Memory-side outputs are registered, decoded from the state being entered.
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    be_d    = 2'b00;
    addr_d  = '0;
    wdata_d = '0;
    done_d  = (state_d == S_DONE);

    unique case (state_d)
      S_IND: begin
        rd_d   = 1'b1;
        addr_d = {mem_address[WIDTH-1:1], 1'b0};
        be_d   = 2'b11;
      end
      S_ACC: begin
        if (state_q == S_ACC) begin
          rd_d    = rd_q;
          wr_d    = wr_q;
          be_d    = be_q;
          addr_d  = addr_q;
          wdata_d = wdata_q;
        end else begin
          // Coming from IND the pointer is the word being returned right now.
          base = (state_q == S_IND) ? dmem_rdata : mem_address;
          rd_d = op_is_load(op_d);
          wr_d = !op_is_load(op_d);
          if (op_is_byte(op_d)) begin
            addr_d  = base;
            be_d    = base[0] ? 2'b10 : 2'b01;
            wdata_d = {mem_store_data[7:0], mem_store_data[7:0]};
          end else begin
            addr_d  = {base[WIDTH-1:1], 1'b0};
            be_d    = 2'b11;
            wdata_d = mem_store_data;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign dmem_address     = addr_q;
  assign dmem_read        = rd_q;
  assign dmem_write       = wr_q;
  assign dmem_byte_enable = be_q;
  assign dmem_wdata       = wdata_q;
  assign mem_rdata        = rdata_q;
  assign mem_done         = done_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: a memory responder with random wait states,
// a reference memory model predicting accesses and load results, and a decoupled monitor.
module tb_mem_stage_ctrl;

  localparam logic [2:0] LDR = 3'b001, LDB = 3'b010, STR = 3'b011, STB = 3'b100;
  localparam logic [2:0] LDI = 3'b101, STI = 3'b110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_valid = 1'b0;
  logic [2:0]  mem_op = 3'b000;
  logic        mem_flush = 1'b0;
  logic [15:0] mem_address = '0;
  logic [15:0] mem_store_data = '0;
  logic [15:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_resp = 1'b0;
  logic [15:0] mem_rdata;
  logic        mem_stall;
  logic        mem_done;

  mem_stage_ctrl #(.WIDTH(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_valid        (mem_valid),
    .mem_op           (mem_op),
    .mem_flush        (mem_flush),
    .mem_address      (mem_address),
    .mem_store_data   (mem_store_data),
    .dmem_address     (dmem_address),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp),
    .mem_rdata        (mem_rdata),
    .mem_stall        (mem_stall),
    .mem_done         (mem_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_write;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } acc_t;

  acc_t        exp_acc_q[$];
  logic [15:0] exp_rd_q[$];
  int          wait_q[$];
  logic [15:0] model_mem [logic [15:0]];
  logic [15:0] phys_mem  [logic [15:0]];
  logic [15:0] model_rdata = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          late_req_cnt = 0;
  int          late_done_cnt = 0;
  int          cur_wait = -1;

  function automatic logic [15:0] init_word(input logic [15:0] wa);
    logic [15:0] r;
    r = wa * 16'h9E37;
    return r ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] model_word(input logic [15:0] a);
    logic [15:0] wa;
    wa = {a[15:1], 1'b0};
    return model_mem.exists(wa) ? model_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [15:0] phys_word(input logic [15:0] a);
    logic [15:0] wa;
    wa = {a[15:1], 1'b0};
    return phys_mem.exists(wa) ? phys_mem[wa] : init_word(wa);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    model_mem[{a[15:1], 1'b0}] = v;
    phys_mem[{a[15:1], 1'b0}]  = v;
  endtask

  task automatic push_acc(input logic w, input logic [15:0] a, input logic [1:0] be,
                          input logic [15:0] d, input int wt);
    acc_t x;
    x.is_write = w;
    x.addr     = a;
    x.be       = be;
    x.wdata    = d;
    exp_acc_q.push_back(x);
    wait_q.push_back(wt);
  endtask

  // Data memory: answers each request after its scheduled wait, injects stray responses when idle.
  initial begin
    logic [15:0] w;
    forever begin
      @(negedge clk);
      dmem_resp = 1'b0;
      if (!rst_n) begin
        cur_wait = -1;
      end else if (late_req_cnt != late_done_cnt) begin
        late_done_cnt = late_req_cnt;
        dmem_resp  = 1'b1;
        dmem_rdata = 16'hDEAD;
      end else if (dmem_read || dmem_write) begin
        if (cur_wait < 0) cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        if (cur_wait == 0) begin
          dmem_resp = 1'b1;
          if (dmem_read) begin
            dmem_rdata = phys_word(dmem_address);
          end else begin
            w = phys_word(dmem_address);
            if (dmem_byte_enable[0]) w[7:0]  = dmem_wdata[7:0];
            if (dmem_byte_enable[1]) w[15:8] = dmem_wdata[15:8];
            phys_mem[{dmem_address[15:1], 1'b0}] = w;
            dmem_rdata = 16'($urandom);
          end
          cur_wait = -1;
        end else begin
          cur_wait--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        dmem_resp  = 1'b1;
        dmem_rdata = 16'($urandom);
      end
    end
  end

  // Monitor: compares each completed access and each retired op against the scoreboard.
  initial begin
    acc_t        x;
    logic [15:0] r;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (dmem_read || dmem_write)
          check("rd_wr_exclusive", {15'b0, dmem_read & dmem_write}, 16'h0000);
        if (dmem_resp && (dmem_read || dmem_write)) begin
          if (exp_acc_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_access: got addr %h rd %b wr %b, required none", dmem_address, dmem_read, dmem_write);
          end else begin
            x = exp_acc_q.pop_front();
            check("acc_is_write", {15'b0, dmem_write}, {15'b0, x.is_write});
            check("acc_addr", dmem_address, x.addr);
            check("acc_be", {14'b0, dmem_byte_enable}, {14'b0, x.be});
            if (x.is_write) check("acc_wdata", dmem_wdata, x.wdata);
          end
        end
        if (mem_done) begin
          if (exp_rd_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got mem_done 1, required 0");
          end else begin
            r = exp_rd_q.pop_front();
            check("mem_rdata", mem_rdata, r);
          end
        end
      end
    end
  end

  // Issue one instruction at the negedge+1 phase and follow it to retirement.
  // fmode: 0 none, 1 flushed in IDLE, 2 flush raised once the first request is visible.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d,
                       input int fmode, input int w0, input int w1);
    logic        real_op, ind, done_exp, flushed;
    logic [15:0] wa, ptr, ea, w;
    int          exp_stall, stalls, c;
    real_op   = (op != 3'b000) && (op != 3'b111);
    ind       = (op == LDI) || (op == STI);
    wa        = {a[15:1], 1'b0};
    done_exp  = 1'b0;
    exp_stall = 0;
    if (real_op && fmode != 1) begin
      if (ind) begin
        ptr = model_word(a);
        ea  = {ptr[15:1], 1'b0};
        push_acc(1'b0, wa, 2'b11, 16'h0000, w0);
        if (fmode == 2) begin
          exp_stall = 1 + (w0 + 1);
        end else begin
          push_acc(op == STI, ea, 2'b11, d, w1);
          if (op == LDI) model_rdata = model_word(ea);
          else           model_mem[ea] = d;
          exp_rd_q.push_back(model_rdata);
          exp_stall = 1 + (w0 + 1) + (w1 + 1);
          done_exp  = 1'b1;
        end
      end else begin
        w = model_word(a);
        case (op)
          LDR: begin push_acc(1'b0, wa, 2'b11, 16'h0000, w0); model_rdata = w; end
          LDB: begin
            push_acc(1'b0, a, a[0] ? 2'b10 : 2'b01, 16'h0000, w0);
            model_rdata = {8'h00, a[0] ? w[15:8] : w[7:0]};
          end
          STR: begin push_acc(1'b1, wa, 2'b11, d, w0); model_mem[wa] = d; end
          default: begin
            push_acc(1'b1, a, a[0] ? 2'b10 : 2'b01, {d[7:0], d[7:0]}, w0);
            if (a[0]) w[15:8] = d[7:0];
            else      w[7:0]  = d[7:0];
            model_mem[wa] = w;
          end
        endcase
        exp_rd_q.push_back(model_rdata);
        exp_stall = w0 + 2;
        done_exp  = 1'b1;
      end
    end

    mem_valid      = 1'b1;
    mem_op         = op;
    mem_address    = a;
    mem_store_data = d;
    mem_flush      = (fmode == 1);
    #1;
    stalls  = 0;
    flushed = 1'b0;
    for (c = 0; c < 200; c++) begin
      if (!mem_stall) break;
      stalls++;
      if (fmode == 2 && !flushed && (dmem_read || dmem_write)) begin
        mem_flush = 1'b1;
        flushed   = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    if (c == 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stall_timeout: got stall still high after 200 cycles, required release");
    end
    check("stall_cycles", 16'(stalls), 16'(exp_stall));
    check("done_pulse", {15'b0, mem_done}, {15'b0, done_exp});
    if (!done_exp) begin
      repeat (2) begin
        @(negedge clk);
        #1;
        check("idle_no_stall", {15'b0, mem_stall}, 16'h0000);
        check("idle_no_req", {14'b0, dmem_read, dmem_write}, 16'h0000);
      end
    end
    mem_valid = 1'b0;
    mem_flush = 1'b0;
    mem_op    = 3'($urandom);
    repeat (1 + $urandom_range(0, 2)) begin
      @(negedge clk);
      #1;
      if (done_exp) begin
        check("done_one_cycle", {15'b0, mem_done}, 16'h0000);
        done_exp = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read"},  {15'b0, dmem_read}, 16'h0000);
    check({tag, "_write"}, {15'b0, dmem_write}, 16'h0000);
    check({tag, "_be"},    {14'b0, dmem_byte_enable}, 16'h0000);
    check({tag, "_addr"},  dmem_address, 16'h0000);
    check({tag, "_wdata"}, dmem_wdata, 16'h0000);
    check({tag, "_rdata"}, mem_rdata, 16'h0000);
    check({tag, "_done"},  {15'b0, mem_done}, 16'h0000);
    check({tag, "_stall"}, {15'b0, mem_stall}, 16'h0000);
  endtask

  task automatic reset_mid_store();
    int c;
    wait_q.delete();
    wait_q.push_back(60);
    mem_valid      = 1'b1;
    mem_op         = STR;
    mem_address    = 16'h5000;
    mem_store_data = 16'h1234;
    for (c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (dmem_write) break;
    end
    check("pre_reset_write", {15'b0, dmem_write}, 16'h0001);
    mem_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    exp_acc_q.delete();
    wait_q.delete();
    model_rdata = '0;
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    late_req_cnt++;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("late_resp");
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    preload(16'h3004, 16'hBEEF);
    issue(LDR, 16'h3005, 16'h0000, 0, 2, 0);
    preload(16'h4000, 16'hA55A);
    issue(LDB, 16'h4001, 16'h0000, 0, 0, 0);
    issue(STB, 16'h4000, 16'h12CD, 0, 1, 0);
    issue(LDR, 16'h4000, 16'h0000, 0, 0, 0);
    preload(16'h2000, 16'h6003);
    preload(16'h6002, 16'h1111);
    issue(LDI, 16'h2000, 16'h0000, 0, 0, 0);
    preload(16'h2100, 16'h7000);
    issue(STI, 16'h2100, 16'h55AA, 0, 0, 0);
    issue(LDR, 16'h7000, 16'h0000, 0, 1, 0);
    issue(LDR, 16'h3005, 16'h0000, 1, 0, 0);
    issue(STI, 16'h2100, 16'hFFFF, 2, 1, 0);
    issue(LDR, 16'h7001, 16'h0000, 0, 0, 0);
    issue(STR, 16'h3006, 16'h0BAD, 2, 2, 0);
    issue(LDB, 16'h3007, 16'h0000, 0, 0, 0);
    issue(3'b000, 16'h3006, 16'h0000, 0, 0, 0);
    issue(3'b111, 16'h3006, 16'h0000, 0, 0, 0);

    reset_mid_store();
    issue(LDR, 16'h3005, 16'h0000, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      int         r, fm;
      op = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      fm = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      issue(op, 16'h1000 + 16'($urandom_range(0, 63)), 16'($urandom), fm,
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    #3;
    check("acc_queue_drained", 16'(exp_acc_q.size()), 16'h0000);
    check("done_queue_drained", 16'(exp_rd_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
